// File: rtl/lbm_pkg.sv
// Shared constants and types for the LBM chunk unload path.
// - ADDR_W / DATA_W / NUM_DIR : BRAM address width, direction word width, directions per cell
// - DIR_* : beat index of each direction; the beat order on the stream follows these values
// - unload_state_e : state encoding of the unload FSM
package lbm_pkg;

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned NUM_DIR = 9;
   localparam int unsigned BEAT_W  = 4;

   localparam int unsigned DIR_NULL = 0;
   localparam int unsigned DIR_N    = 1;
   localparam int unsigned DIR_NE   = 2;
   localparam int unsigned DIR_E    = 3;
   localparam int unsigned DIR_SE   = 4;
   localparam int unsigned DIR_S    = 5;
   localparam int unsigned DIR_SW   = 6;
   localparam int unsigned DIR_W    = 7;
   localparam int unsigned DIR_NW   = 8;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StCapture,
      StSend,
      StFinish
   } unload_state_e;

endpackage

// File: rtl/axis_word_serializer.sv
// Holds the nine direction words of one cell and emits them as nine AXI-Stream beats.
// - clk_i / rst_i  : clock, synchronous active-high reset
// - load_i         : capture rdata_i into the hold register and start a new cell
// - rdata_i        : {nw,w,sw,s,se,e,ne,n,null} direction words
// - last_cell_i    : the cell being loaded is the final one of the job (drives tlast)
// - tready_i       : downstream ready
// - tdata_o / tvalid_o / tlast_o : stream outputs
// - cell_done_o    : the last beat of the current cell is accepted this cycle
module axis_word_serializer
   import lbm_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       load_i,
   input  logic [NUM_DIR*DATA_W-1:0]  rdata_i,
   input  logic                       last_cell_i,
   input  logic                       tready_i,
   output logic [DATA_W-1:0]          tdata_o,
   output logic                       tvalid_o,
   output logic                       tlast_o,
   output logic                       cell_done_o
);

   localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(DIR_NW);

   logic [DATA_W-1:0] hold_q [NUM_DIR];
   logic [BEAT_W-1:0] beat_idx_q;
   logic              valid_q;
   logic              last_cell_q;
   logic              accept;

   assign accept = valid_q && tready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(NUM_DIR); i++) begin
            hold_q[i] <= '0;
         end
         beat_idx_q  <= '0;
         valid_q     <= 1'b0;
         last_cell_q <= 1'b0;
      end else if (load_i) begin
         for (int i = 0; i < int'(NUM_DIR); i++) begin
            hold_q[i] <= rdata_i[i*DATA_W +: DATA_W];
         end
         beat_idx_q  <= '0;
         valid_q     <= 1'b1;
         last_cell_q <= last_cell_i;
      end else if (accept) begin
         if (beat_idx_q == LastBeat) begin
            beat_idx_q <= '0;
            valid_q    <= 1'b0;
         end else begin
            beat_idx_q <= beat_idx_q + 1'b1;
         end
      end
   end

   // Word select from registered state only, so tdata cannot move during a stall.
   always_comb begin
      tdata_o = '0;
      for (int i = 0; i < int'(NUM_DIR); i++) begin
         if (valid_q && (beat_idx_q == BEAT_W'(i))) begin
            tdata_o = hold_q[i];
         end
      end
   end

   assign tvalid_o    = valid_q;
   assign tlast_o     = valid_q && last_cell_q && (beat_idx_q == LastBeat);
   assign cell_done_o = accept && (beat_idx_q == LastBeat);

endmodule

// File: rtl/chunk_unload_streamer.sv
// Drains a chunk of LBM cells from the nine direction BRAMs to an AXI-Stream master.
// - m00_axis_aclk / m00_axis_areset : clock, synchronous active-high reset
// - start / base_addr / num_cells   : job request, latched when accepted in idle
// - unload_active                   : this block owns the BRAM read port
// - bram_addr / bram_rdata          : shared read address, nine words returned one cycle later
// - m00_axis_t*                     : one direction word per beat, tlast on the final beat of the job
// - done                            : one-cycle pulse at job completion
module chunk_unload_streamer
   import lbm_pkg::*;
(
   input  logic                       m00_axis_aclk,
   input  logic                       m00_axis_areset,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          base_addr,
   input  logic [ADDR_W:0]            num_cells,
   output logic                       unload_active,
   output logic [ADDR_W-1:0]          bram_addr,
   input  logic [NUM_DIR*DATA_W-1:0]  bram_rdata,
   output logic [DATA_W-1:0]          m00_axis_tdata,
   output logic                       m00_axis_tvalid,
   input  logic                       m00_axis_tready,
   output logic                       m00_axis_tlast,
   output logic                       done
);

   unload_state_e     state_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   num_q;
   logic [ADDR_W:0]   cell_cnt_q;
   logic [ADDR_W:0]   cell_cnt_d;
   logic [ADDR_W-1:0] bram_addr_q;
   logic [ADDR_W-1:0] bram_addr_d;
   logic              active_q;
   logic              done_q;
   logic              last_cell;
   logic              cell_done;

   assign cell_cnt_d  = cell_cnt_q + 1'b1;
   // Address of the next cell; the add wraps at the top of the BRAM.
   assign bram_addr_d = base_q + cell_cnt_d[ADDR_W-1:0];
   assign last_cell   = (cell_cnt_q == (num_q - 1'b1));

   always_ff @(posedge m00_axis_aclk) begin
      if (m00_axis_areset) begin
         state_q     <= StIdle;
         base_q      <= '0;
         num_q       <= '0;
         cell_cnt_q  <= '0;
         bram_addr_q <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  base_q     <= base_addr;
                  num_q      <= num_cells;
                  cell_cnt_q <= '0;
                  active_q   <= 1'b1;
                  if (num_cells == '0) begin
                     done_q  <= 1'b1;
                     state_q <= StFinish;
                  end else begin
                     // Address is presented during the ISSUE cycle itself.
                     bram_addr_q <= base_addr;
                     state_q     <= StIssue;
                  end
               end
            end
            StIssue: begin
               state_q <= StCapture;
            end
            StCapture: begin
               state_q <= StSend;
            end
            StSend: begin
               if (cell_done) begin
                  if (last_cell) begin
                     done_q  <= 1'b1;
                     state_q <= StFinish;
                  end else begin
                     cell_cnt_q  <= cell_cnt_d;
                     bram_addr_q <= bram_addr_d;
                     state_q     <= StIssue;
                  end
               end
            end
            StFinish: begin
               done_q      <= 1'b0;
               active_q    <= 1'b0;
               bram_addr_q <= '0;
               state_q     <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   axis_word_serializer u_serializer (
      .clk_i       (m00_axis_aclk),
      .rst_i       (m00_axis_areset),
      .load_i      (state_q == StCapture),
      .rdata_i     (bram_rdata),
      .last_cell_i (last_cell),
      .tready_i    (m00_axis_tready),
      .tdata_o     (m00_axis_tdata),
      .tvalid_o    (m00_axis_tvalid),
      .tlast_o     (m00_axis_tlast),
      .cell_done_o (cell_done)
   );

   assign unload_active = active_q;
   assign bram_addr     = bram_addr_q;
   assign done          = done_q;

endmodule

// File: tb/tb_chunk_unload_streamer.sv
// Directed bench for chunk_unload_streamer with a behavioural BRAM (word = address + direction).
module tb_chunk_unload_streamer;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [11:0]  base_addr;
   logic [12:0]  num_cells;
   logic         unload_active;
   logic [11:0]  bram_addr;
   logic [143:0] bram_rdata;
   logic [15:0]  tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic         done;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   chunk_unload_streamer dut (
      .m00_axis_aclk   (clk),
      .m00_axis_areset (rst),
      .start           (start),
      .base_addr       (base_addr),
      .num_cells       (num_cells),
      .unload_active   (unload_active),
      .bram_addr       (bram_addr),
      .bram_rdata      (bram_rdata),
      .m00_axis_tdata  (tdata),
      .m00_axis_tvalid (tvalid),
      .m00_axis_tready (tready),
      .m00_axis_tlast  (tlast),
      .done            (done)
   );

   // One-cycle read latency BRAM model.
   always @(posedge clk) begin
      for (int d = 0; d < 9; d++) begin
         bram_rdata[d*16 +: 16] <= 16'({4'b0, bram_addr}) + 16'(d);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one job from a sample point (#1 after an edge) and drains it beat by beat.
   // bad counts data/tlast/address/stability/pitch errors; done_ok covers the finish handshake.
   task automatic run_job(input int base, input int num, input int bp, input int restart_at,
                          output int beats, output int lasts, output int bad,
                          output int done_ok, output int lat, output int addr_t1);
      int          c = 0;
      int          d = 0;
      int          cyc;
      int          guard = 0;
      int          last_first = -1;
      logic        stall = 1'b0;
      logic [15:0] pd = '0;
      logic        pl = 1'b0;
      logic [15:0] expd;
      beats = 0; lasts = 0; bad = 0; done_ok = 0; lat = -1;
      base_addr = base[11:0];
      num_cells = num[12:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = 12'd100;
      num_cells = 13'd1;
      cyc = 1;
      addr_t1 = int'(bram_addr);
      while (c < num && guard < 200000) begin
         guard++;
         if (done) bad++;
         if (stall && (!tvalid || tdata !== pd || tlast !== pl)) bad++;
         if (tvalid) begin
            expd = 16'((base + c) % 4096 + d);
            if (tdata !== expd || tlast !== ((c == num - 1) && (d == 8))) bad++;
            if (d == 0 && bram_addr !== 12'((base + c) % 4096)) bad++;
            if (bp == 0 && d == 0) begin
               if (c == 0) lat = cyc;
               else if (cyc - last_first != 11) bad++;
               last_first = cyc;
            end
         end
         start = (restart_at >= 0) && (beats == restart_at);
         tready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
         stall = tvalid && !tready;
         pd = tdata;
         pl = tlast;
         if (tvalid && tready) begin
            beats++;
            if (tlast) lasts++;
            d++;
            if (d == 9) begin
               d = 0;
               c++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (guard >= 200000) bad++;
      done_ok = int'(done === 1'b1 && unload_active === 1'b1 && tvalid === 1'b0);
      @(posedge clk); #1;
      if (!(done === 1'b0 && unload_active === 1'b0 && bram_addr === 12'd0)) done_ok = 0;
   endtask

   int beats, lasts, bad, done_ok, lat, addr_t1, stray;

   initial begin
      rst = 1'b1; start = 1'b0; tready = 1'b0; base_addr = '0; num_cells = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tvalid", tvalid, 0);
      chk("reset_active", unload_active, 0);
      chk("reset_done", done, 0);
      chk("reset_addr", bram_addr, 0);
      chk("reset_tlast_tdata", {tlast, tdata}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic drain, full-rate tready.
      run_job(0, 4, 0, -1, beats, lasts, bad, done_ok, lat, addr_t1);
      chk("basic_beats", beats, 36);
      chk("basic_tlast_count", lasts, 1);
      chk("basic_data_pitch", bad, 0);
      chk("basic_done", done_ok, 1);
      chk("basic_addr_t1", addr_t1, 0);
      chk("basic_first_tvalid", lat, 3);

      // Backpressure: ~30% of cycles not ready.
      run_job(0, 4, 30, -1, beats, lasts, bad, done_ok, lat, addr_t1);
      chk("bp_beats", beats, 36);
      chk("bp_tlast_count", lasts, 1);
      chk("bp_data_stable", bad, 0);
      chk("bp_done", done_ok, 1);

      // Address wrap 4094, 4095, 0.
      run_job(4094, 3, 0, -1, beats, lasts, bad, done_ok, lat, addr_t1);
      chk("wrap_beats", beats, 27);
      chk("wrap_tlast_count", lasts, 1);
      chk("wrap_data_addr", bad, 0);
      chk("wrap_done", done_ok, 1);
      chk("wrap_addr_t1", addr_t1, 4094);

      // Zero-length job: done in the cycle after start, no beats.
      run_job(7, 0, 0, -1, beats, lasts, bad, done_ok, lat, addr_t1);
      chk("zero_beats", beats, 0);
      chk("zero_done", done_ok, 1);

      // Second start mid-job is ignored.
      run_job(20, 2, 0, 5, beats, lasts, bad, done_ok, lat, addr_t1);
      chk("restart_beats", beats, 18);
      chk("restart_tlast_count", lasts, 1);
      chk("restart_data", bad, 0);
      chk("restart_done", done_ok, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("restart_no_new_job", {unload_active, tvalid}, 0);

      // Reset during SEND aborts the job.
      base_addr = 12'd10; num_cells = 13'd2; tready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10 && !tvalid; i++) begin
         @(posedge clk); #1;
      end
      chk("abort_reached_send", tvalid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_outputs", {tvalid, unload_active, done}, 0);
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (tvalid || done || unload_active) stray++;
      end
      chk("abort_quiet", stray, 0);

      // Simultaneous start and reset: reset wins.
      base_addr = 12'd0; num_cells = 13'd1; start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      chk("reset_beats_start", unload_active, 0);
      @(posedge clk); #1;
      chk("reset_beats_start_after", {unload_active, tvalid}, 0);

      // Full chunk: 4096 cells.
      run_job(0, 4096, 0, -1, beats, lasts, bad, done_ok, lat, addr_t1);
      chk("full_beats", beats, 36864);
      chk("full_tlast_count", lasts, 1);
      chk("full_data", bad, 0);
      chk("full_done", done_ok, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
